// File: rtl/cpu_halt_dump_controller.sv
// Halt sequencer and data-memory arbiter: passes CPU traffic through until the
// all-zero halt instruction, drains, then streams every data-memory word out.
module cpu_halt_dump_controller #(
   parameter int MEM_WORDS    = 64,
   parameter int DRAIN_CYCLES = 19
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cpu_instr,
   input  logic [31:0] cpu_dm_a,
   input  logic        cpu_dm_we,
   input  logic [31:0] cpu_dm_wd,
   output logic [31:0] dm_a,
   output logic        dm_we,
   output logic [31:0] dm_wd,
   input  logic [31:0] dm_rd,
   output logic        cpu_stall,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic [31:0] dump_index,
   output logic [31:0] dump_data,
   output logic        done,
   output logic [31:0] run_cycles,
   output logic [1:0]  state
);

   localparam int IDX_W = $clog2(MEM_WORDS) + 1;
   localparam int DRN_W = $clog2(DRAIN_CYCLES) + 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MEM_WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES);
   localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_DUMP  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [DRN_W-1:0] drain_cnt_q;
   logic [31:0]      run_cycles_q;
   logic             pass_through;

   // Dump handshake: a word moves on any rising edge where dump_valid and
   // dump_ready are both high; while dump_ready is low the word holds steady.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_RUN;
         idx_q        <= '0;
         drain_cnt_q  <= '0;
         run_cycles_q <= '0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (run_cycles_q != '1) begin
                  run_cycles_q <= run_cycles_q + 32'd1;
               end
               if (cpu_instr == 32'd0) begin
                  state_q     <= S_DRAIN;
                  drain_cnt_q <= DRN_ONE;
               end
            end
            S_DRAIN: begin
               // Later halt words are ignored; the drain count never restarts.
               if (drain_cnt_q == DRN_LAST) begin
                  state_q <= S_DUMP;
                  idx_q   <= '0;
               end else begin
                  drain_cnt_q <= drain_cnt_q + DRN_ONE;
               end
            end
            S_DUMP: begin
               if (dump_ready) begin
                  if (idx_q == IDX_LAST) begin
                     state_q <= S_DONE;
                  end else begin
                     idx_q <= idx_q + IDX_ONE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_DONE;
            end
            default: begin
               state_q <= S_RUN;
            end
         endcase
      end
   end

   assign pass_through = (state_q == S_RUN) || (state_q == S_DRAIN);

   assign dm_a       = pass_through ? cpu_dm_a : (32'(idx_q) << 2);
   assign dm_we      = pass_through & cpu_dm_we;
   assign dm_wd      = pass_through ? cpu_dm_wd : 32'd0;
   assign cpu_stall  = ~pass_through;
   assign dump_valid = (state_q == S_DUMP);
   assign dump_index = 32'(idx_q);
   assign dump_data  = dump_valid ? dm_rd : 32'd0;
   assign done       = (state_q == S_DONE);
   assign run_cycles = run_cycles_q;
   assign state      = state_q;

endmodule

// File: tb/tb_cpu_halt_dump_controller.sv
// Bench for cpu_halt_dump_controller: random CPU traffic and handshake patterns
// against a timeline model of halt, drain, dump and done.
module tb_cpu_halt_dump_controller;

   localparam int MW  = 64;
   localparam int DC  = 19;
   localparam int MW2 = 1;
   localparam int DC2 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] cpu_instr, cpu_dm_a, cpu_dm_wd;
   logic        cpu_dm_we;
   logic [31:0] dm_a, dm_wd, dm_rd;
   logic        dm_we;
   logic        cpu_stall, dump_valid, dump_ready, done;
   logic [31:0] dump_index, dump_data, run_cycles;
   logic [1:0]  state;

   logic        rst2_n;
   logic [31:0] cpu_instr2, cpu_dm_a2, cpu_dm_wd2;
   logic        cpu_dm_we2;
   logic [31:0] dm_a2, dm_wd2, dm_rd2;
   logic        dm_we2;
   logic        cpu_stall2, dump_valid2, dump_ready2, done2;
   logic [31:0] dump_index2, dump_data2, run_cycles2;
   logic [1:0]  state2;

   cpu_halt_dump_controller #(.MEM_WORDS(MW), .DRAIN_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_instr(cpu_instr), .cpu_dm_a(cpu_dm_a),
      .cpu_dm_we(cpu_dm_we), .cpu_dm_wd(cpu_dm_wd), .dm_a(dm_a), .dm_we(dm_we),
      .dm_wd(dm_wd), .dm_rd(dm_rd), .cpu_stall(cpu_stall), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_index(dump_index), .dump_data(dump_data),
      .done(done), .run_cycles(run_cycles), .state(state)
   );

   cpu_halt_dump_controller #(.MEM_WORDS(MW2), .DRAIN_CYCLES(DC2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .cpu_instr(cpu_instr2), .cpu_dm_a(cpu_dm_a2),
      .cpu_dm_we(cpu_dm_we2), .cpu_dm_wd(cpu_dm_wd2), .dm_a(dm_a2), .dm_we(dm_we2),
      .dm_wd(dm_wd2), .dm_rd(dm_rd2), .cpu_stall(cpu_stall2), .dump_valid(dump_valid2),
      .dump_ready(dump_ready2), .dump_index(dump_index2), .dump_data(dump_data2),
      .done(done2), .run_cycles(run_cycles2), .state(state2)
   );

   // Data memory with combinational read; preload has priority over writes.
   logic [31:0] mem     [MW];
   logic [31:0] pre_img [MW];
   logic        pre_load = 1'b0;

   always @(posedge clk) begin
      if (pre_load) begin
         for (int i = 0; i < MW; i++) mem[i] <= pre_img[i];
      end else if (dm_we) begin
         mem[dm_a[7:2]] <= dm_wd;
      end
   end
   assign dm_rd  = mem[dm_a[7:2]];
   assign dm_rd2 = ~dm_a2;

   logic [31:0] exp_mem [MW];
   logic [31:0] got     [MW];
   logic [31:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input bit preload);
      cpu_dm_we  = 1'b0;
      cpu_instr  = 32'h1;
      dump_ready = 1'b0;
      rst_n      = 1'b0;
      if (preload) begin
         for (int i = 0; i < MW; i++) begin
            pre_img[i] = $urandom();
            exp_mem[i] = pre_img[i];
         end
      end
      pre_load = preload;
      @(posedge clk); #2;
      pre_load  = 1'b0;
      cpu_dm_a  = 32'h0000_00A4;
      cpu_dm_wd = $urandom();
      cpu_dm_we = 1'b1;
      #1;
      chk("rst_state", {30'h0, state}, 32'd0);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      chk("rst_valid", 32'(dump_valid), 32'd0);
      chk("rst_index", dump_index, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_run_cycles", run_cycles, 32'd0);
      chk("rst_dm_a", dm_a, cpu_dm_a);
      chk("rst_dm_we", 32'(dm_we), 32'd1);
      chk("rst_dm_wd", dm_wd, cpu_dm_wd);
      cpu_dm_we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ph: 0 run, 1 drain, 2 dump, 3 done, as seen between edges.
   // mode: 0 ready held high, 1 ready pattern 0,0,1, 2 random ready.
   task automatic run_dump(input int halt_at, input int mode, input int abort_idx, input bit drain_wr);
      int ph = 0;
      int t = 0;
      int n = 0;
      int k = 0;
      int done_seen = 0;
      int hs = 0;
      int dut_dump = 0;
      int exp_dump;
      bit aborted = 1'b0;
      logic [31:0] ea;
      while (n < 1500 && done_seen < 3 && !aborted) begin
         if (n < halt_at) cpu_instr = $urandom() | 32'h1;
         else if (n == halt_at) cpu_instr = 32'h0;
         else cpu_instr = $urandom_range(0, 1) ? 32'h0 : 32'h8C01_0004;
         cpu_dm_we = 1'b0;
         cpu_dm_a  = {24'h0, 6'($urandom_range(0, MW - 1)), 2'b00};
         cpu_dm_wd = $urandom();
         if (ph == 0) begin
            cpu_dm_we = 1'($urandom_range(0, 1));
         end else if (ph == 1 && drain_wr && n == halt_at + 5) begin
            cpu_dm_we = 1'b1; cpu_dm_a = 32'h10; cpu_dm_wd = 32'hDEAD_BEEF;
         end else if (ph >= 2) begin
            cpu_dm_we = 1'b1; cpu_dm_a = 32'h10; cpu_dm_wd = 32'h0BAD_F00D;
         end
         if (ph == 2) begin
            if (mode == 0) dump_ready = 1'b1;
            else if (mode == 1) dump_ready = (k % 3 == 2);
            else dump_ready = 1'($urandom_range(0, 1));
         end else begin
            dump_ready = 1'($urandom_range(0, 1));
         end
         if (ph == 2 && k == 0) begin
            exp_q.delete();
            for (int i = 0; i < MW; i++) exp_q.push_back(exp_mem[i]);
         end
         #1;
         chk("state", {30'h0, state}, ph);
         chk("run_cycles", run_cycles, (n < halt_at + 1) ? n : halt_at + 1);
         if (ph < 2) begin
            chk("pass_dm_a", dm_a, cpu_dm_a);
            chk("pass_dm_we", 32'(dm_we), 32'(cpu_dm_we));
            chk("pass_dm_wd", dm_wd, cpu_dm_wd);
            chk("pass_stall", 32'(cpu_stall), 32'd0);
            chk("pass_valid", 32'(dump_valid), 32'd0);
            chk("pass_index", dump_index, 32'd0);
         end else if (ph == 2) begin
            chk("dump_stall", 32'(cpu_stall), 32'd1);
            chk("dump_valid", 32'(dump_valid), 32'd1);
            chk("dump_dm_we", 32'(dm_we), 32'd0);
            chk("dump_dm_wd", dm_wd, 32'd0);
            chk("dump_dm_a", dm_a, t * 4);
            chk("dump_index", dump_index, t);
            chk("dump_data", dump_data, exp_mem[t]);
         end else begin
            chk("done_flag", 32'(done), 32'd1);
            chk("done_valid", 32'(dump_valid), 32'd0);
            chk("done_stall", 32'(cpu_stall), 32'd1);
            chk("done_dm_we", 32'(dm_we), 32'd0);
            chk("done_index", dump_index, MW - 1);
            done_seen++;
         end
         if (dump_valid) dut_dump++;
         if (dump_valid && dump_ready) begin
            hs++;
            if (exp_q.size() == 0) begin
               chk("sb_overrun", 32'(hs), MW);
            end else begin
               ea = exp_q.pop_front();
               chk("sb_data", dump_data, ea);
            end
            got[dump_index[5:0]] = dump_data;
         end
         if (ph == 2 && t == abort_idx) begin
            cpu_dm_we = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("abort_state", {30'h0, state}, 32'd0);
            chk("abort_valid", 32'(dump_valid), 32'd0);
            chk("abort_stall", 32'(cpu_stall), 32'd0);
            chk("abort_index", dump_index, 32'd0);
            chk("abort_run_cycles", run_cycles, 32'd0);
            chk("abort_dm_a", dm_a, cpu_dm_a);
            aborted = 1'b1;
         end else begin
            if (ph < 2 && cpu_dm_we) exp_mem[cpu_dm_a[7:2]] = cpu_dm_wd;
            if (ph == 2) begin
               k++;
               if (dump_ready) t++;
            end
            @(posedge clk); #2;
            if (n < halt_at) ph = 0;
            else if (n < halt_at + DC) ph = 1;
            else if (t < MW) ph = 2;
            else ph = 3;
            n++;
         end
      end
      if (!aborted) begin
         exp_dump = (mode == 0) ? MW : (mode == 1) ? 3 * MW : k;
         chk("end_done", 32'(done), 32'd1);
         chk("end_handshakes", hs, MW);
         chk("end_dump_cycles", dut_dump, exp_dump);
      end
   endtask

   initial begin
      int hs2;
      int e2;
      rst2_n = 1'b0; cpu_instr2 = 32'h1; cpu_dm_a2 = 32'h0; cpu_dm_we2 = 1'b0;
      cpu_dm_wd2 = 32'h0; dump_ready2 = 1'b1;
      cpu_dm_a = 32'h0; cpu_dm_wd = 32'h0;

      // Continuous ready; one DRAIN write to word 4, DUMP writes must drop.
      do_reset(1'b1);
      run_dump(10, 0, -1, 1'b1);
      chk("word4_drain_write", got[4], 32'hDEAD_BEEF);
      chk("run_cycles_final", run_cycles, 32'd11);

      // Backpressure 0,0,1.
      do_reset(1'b1);
      run_dump(3, 1, -1, 1'b0);

      // Random ready with reset mid-dump, then a halt on the first edge.
      do_reset(1'b1);
      run_dump(5, 2, 17, 1'b0);
      do_reset(1'b0);
      run_dump(0, 0, -1, 1'b0);
      chk("first_edge_run_cycles", run_cycles, 32'd1);

      // Single-word configuration.
      @(posedge clk); #2;
      chk("w1_rst_state", {30'h0, state2}, 32'd0);
      chk("w1_rst_done", 32'(done2), 32'd0);
      @(negedge clk);
      rst2_n = 1'b1;
      cpu_instr2 = 32'h0;
      hs2 = 0;
      for (int c = 0; c < 10; c++) begin
         cpu_dm_a2 = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         #1;
         e2 = (c == 0) ? 0 : (c <= DC2) ? 1 : (c <= DC2 + MW2) ? 2 : 3;
         chk("w1_state", {30'h0, state2}, e2);
         if (e2 >= 2) begin
            chk("w1_dm_we", 32'(dm_we2), 32'd0);
            chk("w1_dm_wd", dm_wd2, 32'd0);
         end
         if (dump_valid2) chk("w1_data", dump_data2, 32'hFFFF_FFFF);
         if (dump_valid2 && dump_ready2) hs2++;
         @(posedge clk); #2;
         cpu_instr2 = $urandom_range(0, 1) ? 32'h0 : 32'h1234_5678;
      end
      chk("w1_handshakes", hs2, 32'd1);
      chk("w1_done", 32'(done2), 32'd1);
      chk("w1_index", dump_index2, 32'd0);
      chk("w1_run_cycles", run_cycles2, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
